// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline Wr stage has priority, aux results queue in a FIFO
// and drain on idle slots or by stealing a slot after STARVE_LIMIT denials. Optional macro: WB_FWD_EN.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_wr_en,
    input  logic [4:0]  pipe_rw,
    input  logic [31:0] pipe_busW,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_rw,
    input  logic [31:0] aux_data,
    output logic        stall_pipe,
    output logic        pending,
    output logic        rf_we,
    output logic [4:0]  rf_rw,
    output logic [31:0] rf_busW
`ifdef WB_FWD_EN
    ,
    input  logic [4:0]  fwd_rs,
    output logic        fwd_hit,
    output logic [31:0] fwd_data
`endif
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);
    localparam logic [CNTW-1:0] FULL  = CNTW'(DEPTH);

    typedef enum logic {S_NORM, S_STEAL} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    wait_q, wait_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_rw_q, rf_rw_d;
    logic [31:0]      rf_busW_q, rf_busW_d;
    logic [4:0]       mem_rw_q   [DEPTH];
    logic [31:0]      mem_data_q [DEPTH];

    logic full, empty, pipe_busy, push_acc, push, pop;

    assign full      = (count_q == FULL);
    assign empty     = (count_q == '0);
    assign pipe_busy = pipe_wr_en && (pipe_rw != 5'd0);
    assign aux_ready = !full && !reset;
    assign push_acc  = aux_valid && aux_ready;
    // r0 results complete the handshake but are never stored
    assign push      = push_acc && (aux_rw != 5'd0);
    assign pending   = !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_NORM;
            wait_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_rw_q   <= '0;
            rf_busW_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rf_we_q   <= rf_we_d;
            rf_rw_q   <= rf_rw_d;
            rf_busW_q <= rf_busW_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rw_q[wr_ptr_q]   <= aux_rw;
            mem_data_q[wr_ptr_q] <= aux_data;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_NORM:  if (pipe_busy && !empty && wait_d == LIMIT) state_d = S_STEAL;
            S_STEAL: state_d = S_NORM;
            default: state_d = S_NORM;
        endcase
    end

    always_comb begin
        stall_pipe = (state_q == S_STEAL);
        pop        = stall_pipe ? !empty : (!pipe_busy && !empty);
    end

    always_comb begin
        rf_we_d   = 1'b0;
        rf_rw_d   = rf_rw_q;
        rf_busW_d = rf_busW_q;
        wait_d    = '0;
        if (pop) begin
            rf_we_d   = 1'b1;
            rf_rw_d   = mem_rw_q[rd_ptr_q];
            rf_busW_d = mem_data_q[rd_ptr_q];
        end else if (!stall_pipe && pipe_busy) begin
            rf_we_d   = 1'b1;
            rf_rw_d   = pipe_rw;
            rf_busW_d = pipe_busW;
            if (!empty) wait_d = (wait_q == LIMIT) ? wait_q : wait_q + CW'(1);
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    assign rf_we   = rf_we_q;
    assign rf_rw   = rf_rw_q;
    assign rf_busW = rf_busW_q;

`ifdef WB_FWD_EN
    // Walk oldest to newest so the last match is the youngest entry
    always_comb begin : fwd_lookup
        logic [AW-1:0] idx;
        idx      = rd_ptr_q;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + AW'(i);
            if (CNTW'(i) < count_q && fwd_rs != 5'd0 && mem_rw_q[idx] == fwd_rs) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data_q[idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected rf writes queued with stimulus, popped on rf_we.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_wr_en;
    logic [4:0]  pipe_rw;
    logic [31:0] pipe_busW;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_rw;
    logic [31:0] aux_data;
    logic        stall_pipe;
    logic        pending;
    logic        rf_we;
    logic [4:0]  rf_rw;
    logic [31:0] rf_busW;
`ifdef WB_FWD_EN
    logic [4:0]  fwd_rs;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .pipe_wr_en (pipe_wr_en),
        .pipe_rw    (pipe_rw),
        .pipe_busW  (pipe_busW),
        .aux_valid  (aux_valid),
        .aux_ready  (aux_ready),
        .aux_rw     (aux_rw),
        .aux_data   (aux_data),
        .stall_pipe (stall_pipe),
        .pending    (pending),
        .rf_we      (rf_we),
        .rf_rw      (rf_rw),
        .rf_busW    (rf_busW)
`ifdef WB_FWD_EN
        ,
        .fwd_rs     (fwd_rs),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data)
`endif
    );

    typedef struct packed {
        logic [4:0]  rw;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    bit  last_acc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [4:0] rw, input logic [31:0] d);
        wr_t w;
        w.rw   = rw;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // One clock: record the handshake, advance, then score any rf write
    task automatic step();
        wr_t e;
        last_acc = aux_valid && aux_ready;
        @(posedge clk);
        #1;
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                check_eq("unexp_wr", {63'd0, rf_we}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_rw", rf_rw, e.rw);
                check_eq("wr_data", rf_busW, e.data);
            end
        end
    endtask

    task automatic drain(input string tag, input int n);
        pipe_wr_en = 1'b0;
        aux_valid  = 1'b0;
        for (int i = 0; i < n; i++) step();
        check_eq({tag, "_sb_empty"}, exp_q.size(), 0);
        check_eq({tag, "_pending"}, pending, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  t3_rw   [3];
        logic [31:0] t3_data [3];
        int idx, c_step;

        reset = 1'b1; pipe_wr_en = 1'b0; pipe_rw = '0; pipe_busW = '0;
        aux_valid = 1'b0; aux_rw = '0; aux_data = '0;
`ifdef WB_FWD_EN
        fwd_rs = '0;
`endif
        step(); step();
        check_eq("rst_aux_ready", aux_ready, 0);
        check_eq("rst_stall", stall_pipe, 0);
        check_eq("rst_pending", pending, 0);
        check_eq("rst_rf_we", rf_we, 0);
        reset = 1'b0;
        #1;
        check_eq("rel_aux_ready", aux_ready, 1);
        check_eq("rel_rf_rw", rf_rw, 0);
        check_eq("rel_rf_busW", rf_busW, 0);

        // Single aux push with an idle pipe
        aux_valid = 1'b1; aux_rw = 5'd5; aux_data = 32'hDEAD;
        push_exp(5'd5, 32'hDEAD);
        step();
        check_eq("t1_acc", last_acc, 1);
        aux_valid = 1'b0;
        check_eq("t1_pend", pending, 1);
        check_eq("t1_no_early_wr", rf_we, 0);
        step();
        check_eq("t1_we", rf_we, 1);
        check_eq("t1_pend_drop", pending, 0);
        step();
        check_eq("t1_we_once", rf_we, 0);
        check_eq("t1_hold_rw", rf_rw, 5);
        check_eq("t1_hold_data", rf_busW, 32'hDEAD);
        drain("t1", 1);

        // Starvation steal with a continuously busy pipe
        pipe_wr_en = 1'b1; pipe_rw = 5'd3; pipe_busW = 32'h11;
        aux_valid = 1'b1; aux_rw = 5'd7; aux_data = 32'h77;
        for (int k = 0; k < 7; k++) begin
            if (k == 5) push_exp(5'd7, 32'h77);
            else        push_exp(5'd3, 32'h11);
            step();
            if (k == 0) aux_valid = 1'b0;
            check_eq("t2_stall", stall_pipe, (k == 4));
        end
        drain("t2", 2);

        // Back-pressure: third push waits for the first pop
        t3_rw   = '{5'd10, 5'd11, 5'd12};
        t3_data = '{32'hA0, 32'hB0, 32'hC0};
        pipe_wr_en = 1'b1; pipe_rw = 5'd3; pipe_busW = 32'h22;
        idx = 0; c_step = -1;
        for (int k = 0; k < 16; k++) begin
            aux_valid = (idx < 3);
            if (idx < 3) begin
                aux_rw   = t3_rw[idx];
                aux_data = t3_data[idx];
            end
            if      (k == 5)  push_exp(5'd10, 32'hA0);
            else if (k == 10) push_exp(5'd11, 32'hB0);
            else if (k == 15) push_exp(5'd12, 32'hC0);
            else              push_exp(5'd3, 32'h22);
            step();
            if (last_acc) begin
                if (idx == 2) c_step = k;
                idx++;
            end
            if (k == 1) check_eq("t3_full_ready", aux_ready, 0);
            check_eq("t3_stall", stall_pipe, (k == 4 || k == 9 || k == 14));
        end
        check_eq("t3_c_step", c_step, 6);
        check_eq("t3_all_acc", idx, 3);
        drain("t3", 2);

        // Pipe write to r0 leaves the slot free; aux push to r0 is dropped
        pipe_wr_en = 1'b1; pipe_rw = 5'd3; pipe_busW = 32'h33;
        aux_valid = 1'b1; aux_rw = 5'd9; aux_data = 32'h99;
        push_exp(5'd3, 32'h33);
        step();
        aux_valid = 1'b0; pipe_rw = 5'd0; pipe_busW = 32'h55;
        push_exp(5'd9, 32'h99);
        step();
        check_eq("t4_aux_rw", rf_rw, 9);
        check_eq("t4_pend", pending, 0);
        step();
        check_eq("t4_r0_no_wr", rf_we, 0);
        aux_valid = 1'b1; aux_rw = 5'd0; aux_data = 32'h1234;
        step();
        check_eq("t4_r0_acc", last_acc, 1);
        aux_valid = 1'b0;
        check_eq("t4_r0_pend", pending, 0);
        step();
        check_eq("t4_r0_no_aux_wr", rf_we, 0);
        drain("t4", 2);

        // Reset during a steal discards buffered entries
        pipe_wr_en = 1'b1; pipe_rw = 5'd3; pipe_busW = 32'h66;
        for (int k = 0; k < 5; k++) begin
            push_exp(5'd3, 32'h66);
            aux_valid = (k < 2);
            aux_rw    = (k == 0) ? 5'd13 : 5'd14;
            aux_data  = (k == 0) ? 32'hD0 : 32'hE0;
            step();
        end
        check_eq("t5_in_steal", stall_pipe, 1);
        check_eq("t5_pend_pre", pending, 1);
        aux_valid = 1'b0;
        reset = 1'b1;
        step();
        check_eq("t5_stall", stall_pipe, 0);
        check_eq("t5_pend", pending, 0);
        check_eq("t5_rf_we", rf_we, 0);
        check_eq("t5_rf_rw", rf_rw, 0);
        reset = 1'b0;
        pipe_wr_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("t5_no_wr", rf_we, 0);
        end
        drain("t5", 1);

`ifdef WB_FWD_EN
        // Forwarding returns the youngest matching entry
        pipe_wr_en = 1'b1; pipe_rw = 5'd3; pipe_busW = 32'h44;
        for (int k = 0; k < 2; k++) begin
            aux_valid = 1'b1; aux_rw = 5'd4;
            aux_data  = (k == 0) ? 32'hA : 32'hB;
            push_exp(5'd3, 32'h44);
            step();
        end
        aux_valid = 1'b0;
        fwd_rs = 5'd4;
        #1;
        check_eq("t6_hit", fwd_hit, 1);
        check_eq("t6_data", fwd_data, 32'hB);
        fwd_rs = 5'd0;
        #1;
        check_eq("t6_r0_hit", fwd_hit, 0);
        check_eq("t6_r0_data", fwd_data, 0);
        fwd_rs = 5'd6;
        #1;
        check_eq("t6_miss_hit", fwd_hit, 0);
        pipe_wr_en = 1'b0;
        push_exp(5'd4, 32'hA);
        push_exp(5'd4, 32'hB);
        step(); step();
        fwd_rs = 5'd4;
        #1;
        check_eq("t6_empty_hit", fwd_hit, 0);
        drain("t6", 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
